// File: rtl/cpu_pkg.sv
// Shared CPU definitions: multiply/divide op encodings, sequencer states and
// the control-unit opcodes that route to the multiply/divide unit.
package cpu_pkg;

  localparam logic MD_OP_MUL = 1'b0;
  localparam logic MD_OP_DIV = 1'b1;

  localparam logic [4:0] OP_MUL = 5'b01111;
  localparam logic [4:0] OP_DIV = 5'b10000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } md_state_t;

endpackage

// File: rtl/md_iter_core.sv
// Radix-2 iteration datapath: shift-add multiply and restoring divide on
// unsigned magnitudes, one step per cycle while step is high.
module md_iter_core
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic             op,
  input  logic [WIDTH-1:0] mag_a,
  input  logic [WIDTH-1:0] mag_b,
  output logic [WIDTH-1:0] acc_hi,
  output logic [WIDTH-1:0] acc_lo
);

  logic             op_q;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH-1:0] r_hi, r_lo;
  logic [WIDTH-1:0] nx_hi, nx_lo;
  logic [WIDTH:0]   sum, r_sh, diff;

  always_comb begin
    sum   = '0;
    r_sh  = '0;
    diff  = '0;
    nx_hi = r_hi;
    nx_lo = r_lo;
    if (op_q == MD_OP_MUL) begin
      // {P, multiplier}: add on LSB, then shift the whole pair right
      sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, opnd} : '0);
      nx_hi = sum[WIDTH:1];
      nx_lo = {sum[0], r_lo[WIDTH-1:1]};
    end else begin
      r_sh = {r_hi, r_lo[WIDTH-1]};
      diff = r_sh - {1'b0, opnd};
      if (!diff[WIDTH]) begin
        nx_hi = diff[WIDTH-1:0];
        nx_lo = {r_lo[WIDTH-2:0], 1'b1};
      end else begin
        nx_hi = r_sh[WIDTH-1:0];
        nx_lo = {r_lo[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q <= MD_OP_MUL;
      opnd <= '0;
      r_hi <= '0;
      r_lo <= '0;
    end else if (load) begin
      op_q <= op;
      r_hi <= '0;
      if (op == MD_OP_MUL) begin
        opnd <= mag_a;
        r_lo <= mag_b;
      end else begin
        opnd <= mag_b;
        r_lo <= mag_a;
      end
    end else if (step) begin
      r_hi <= nx_hi;
      r_lo <= nx_lo;
    end
  end

  assign acc_hi = r_hi;
  assign acc_lo = r_lo;

endmodule

// File: rtl/md_sequencer.sv
// Signed iterative multiply/divide unit: FSM, iteration counter, sign fix-up
// and HI/LO result registers around md_iter_core.
module md_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  md_state_t        state, state_nx;
  logic [CW-1:0]    count;
  logic             op_q, sa_q, sb_q;
  logic             accept, div0, core_load, core_step;
  logic [WIDTH-1:0] mag_a, mag_b, acc_hi, acc_lo, fix_hi, fix_lo;
  logic [2*WIDTH-1:0] prod;

  always_comb begin
    accept    = (state == IDLE) && start;
    div0      = (op == MD_OP_DIV) && (b == '0);
    core_load = accept && !div0;
    core_step = (state == ITER);
    // The most-negative operand maps to itself, read as an unsigned magnitude
    mag_a     = a[WIDTH-1] ? -a : a;
    mag_b     = b[WIDTH-1] ? -b : b;
  end

  md_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk    (clk),
    .rst    (rst),
    .load   (core_load),
    .step   (core_step),
    .op     (op),
    .mag_a  (mag_a),
    .mag_b  (mag_b),
    .acc_hi (acc_hi),
    .acc_lo (acc_lo)
  );

  always_comb begin
    prod   = {acc_hi, acc_lo};
    fix_hi = acc_hi;
    fix_lo = acc_lo;
    if (op_q == MD_OP_MUL) begin
      if (sa_q ^ sb_q) prod = -prod;
      fix_hi = prod[2*WIDTH-1:WIDTH];
      fix_lo = prod[WIDTH-1:0];
    end else begin
      fix_lo = (sa_q ^ sb_q) ? -acc_lo : acc_lo;
      fix_hi = sa_q ? -acc_hi : acc_hi;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start) state_nx = div0 ? DONE : ITER;
      ITER: if (count == CW'(WIDTH - 1)) state_nx = FIX;
      FIX:  state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // busy/done are registered from the state, so they trail it by one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      count       <= '0;
      op_q        <= MD_OP_MUL;
      sa_q        <= 1'b0;
      sb_q        <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state <= state_nx;
      busy  <= (state == ITER) || (state == FIX);
      done  <= (state == DONE);
      if (accept) begin
        op_q        <= op;
        sa_q        <= a[WIDTH-1];
        sb_q        <= b[WIDTH-1];
        count       <= '0;
        div_by_zero <= div0;
        if (div0) begin
          hi <= a;
          lo <= '1;
        end
      end else if (state == ITER) begin
        count <= count + 1'b1;
      end
      if (state == FIX) begin
        hi <= fix_hi;
        lo <= fix_lo;
      end
    end
  end

endmodule

// File: tb/tb_md_sequencer.sv
// Self-checking bench for md_sequencer: directed cases plus randomized traffic
// checked every cycle against an arithmetic reference model.
module tb_md_sequencer;

  localparam int W = 32;
  localparam logic [W-1:0] MIN = 32'h8000_0000;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         op = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] hi, lo;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  md_sequencer #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .hi          (hi),
    .lo          (lo),
    .div_by_zero (div_by_zero)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic: signed 64-bit math, truncating division
  function automatic void ref_calc(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                                   output logic [W-1:0] h, output logic [W-1:0] l,
                                   output logic dz);
    longint sx, sy, p, q, r;
    sx = $signed(x);
    sy = $signed(y);
    dz = 1'b0;
    if (o == 1'b0) begin
      p = sx * sy;
      h = p[63:32];
      l = p[31:0];
    end else if (y == '0) begin
      h  = x;
      l  = '1;
      dz = 1'b1;
    end else begin
      q = sx / sy;
      r = sx % sy;
      h = r[31:0];
      l = q[31:0];
    end
  endfunction

  // Timing model: edge indices at which each observable event must occur
  longint       ecount = 0;
  longint       idle_from = 0, done_edge = -1, load_edge = -1, bs = -1, be = -1;
  logic [W-1:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  logic         m_dbz = 1'b0;

  always @(posedge clk) begin
    logic dz;
    ecount++;
    if (rst) begin
      idle_from = ecount + 1;
      done_edge = -1; load_edge = -1; bs = -1; be = -1;
      m_hi = '0; m_lo = '0; m_dbz = 1'b0;
    end else begin
      if (start && ecount >= idle_from) begin
        ref_calc(op, a, b, p_hi, p_lo, dz);
        m_dbz = dz;
        if (dz) begin
          load_edge = ecount;
          done_edge = ecount + 1;
          bs = -1; be = -1;
        end else begin
          load_edge = ecount + W + 1;
          done_edge = ecount + W + 2;
          bs = ecount + 1;
          be = ecount + W + 1;
        end
        idle_from = done_edge + 1;
      end
      if (ecount == load_edge) begin
        m_hi = p_hi;
        m_lo = p_lo;
      end
    end
  end

  always @(negedge clk) begin
    if (ecount > 0) begin
      chk("busy", busy, (ecount >= bs && ecount <= be));
      chk("done", done, (ecount == done_edge));
      chk("dbz", div_by_zero, m_dbz);
      chk("hi", hi, m_hi);
      chk("lo", lo, m_lo);
    end
  end

  task automatic pulse(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_op(input string name, input logic o, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic [W-1:0] eh, input logic [W-1:0] el,
                        input logic edz, input int elat, input int ebusy);
    int n, nb;
    @(negedge clk);
    pulse(o, x, y);
    n = 0; nb = 0;
    while (!done && n < 200) begin
      if (busy) nb++;
      @(negedge clk);
      n++;
    end
    chk({name, "_lat"}, n, elat);
    chk({name, "_hi"}, hi, eh);
    chk({name, "_lo"}, lo, el);
    chk({name, "_dbz"}, div_by_zero, edz);
    if (ebusy >= 0) chk({name, "_busycyc"}, nb, ebusy);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom % 7)
      0: return '0;
      1: return MIN;
      2: return '1;
      3: return W'($urandom_range(0, 20));
      4: return -W'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int n, ndone;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_dbz", div_by_zero, 0);

    run_op("mul7xm3", 1'b0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 34, 33);
    run_op("divm17x5", 1'b1, -32'sd17, 32'd5, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, 34, -1);
    run_op("div100x0", 1'b1, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, 1'b1, 1, -1);
    run_op("mul2x3", 1'b0, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, 34, -1);
    run_op("divmin", 1'b1, MIN, 32'hFFFF_FFFF, 32'd0, MIN, 1'b0, 34, -1);
    run_op("mulmin", 1'b0, MIN, MIN, 32'h4000_0000, 32'd0, 1'b0, 34, -1);

    // Second request while the first is iterating must be dropped
    @(negedge clk);
    pulse(1'b0, 32'd6, 32'd7);
    n = 0; ndone = 0;
    while (n < 60) begin
      if (n == 5) begin
        start = 1'b1; op = 1'b1; a = 32'd9; b = 32'd3;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        ndone++;
        chk("ovl_hi", hi, 0);
        chk("ovl_lo", lo, 42);
      end
      @(negedge clk);
      n++;
    end
    chk("ovl_ndone", ndone, 1);

    // Reset in the middle of iteration
    pulse(1'b0, 32'd123, 32'd456);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_hi", hi, 0);
    chk("mid_rst_lo", lo, 0);
    run_op("div12x4", 1'b1, 32'd12, 32'd4, 32'd0, 32'd3, 1'b0, 34, -1);

    // Random traffic: extra start pulses land while busy and must be ignored
    for (int i = 0; i < 4000; i++) begin
      start = ($urandom % 4 == 0);
      op    = $urandom % 2;
      a     = pick();
      b     = pick();
      rst   = ($urandom % 1500 == 0);
      @(negedge clk);
    end
    start = 1'b0;
    rst   = 1'b0;
    repeat (40) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
